// File: rtl/parity_pkg.sv
// Shared types and helpers for the streaming parity/LRC frame generator.
//   state_e : frame sequencing state (DATA words, then one TRAILER beat)
//   par_of  : reduced XOR of a word, inverted when odd parity is selected
package parity_pkg;

  typedef enum logic {
    DATA    = 1'b0,
    TRAILER = 1'b1
  } state_e;

  // par_of takes a fixed-width word. Narrower callers zero-extend, which
  // leaves the XOR reduction unchanged.
  localparam int PAR_MAX_W = 64;

  function automatic logic par_of(input logic [PAR_MAX_W-1:0] word,
                                  input logic                 odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/parity_tree.sv
// Combinational parity of one WIDTH-bit word.
//   word : input word
//   par  : XOR of word bits, inverted when ODD=1
module parity_tree
  import parity_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit ODD   = 1'b0
) (
  input  logic [WIDTH-1:0] word,
  output logic             par
);

  if (WIDTH <= PAR_MAX_W) begin : g_pkg
    logic [PAR_MAX_W-1:0] word_ext;

    always_comb begin
      word_ext              = '0;
      word_ext[WIDTH-1:0]   = word;
    end

    assign par = par_of(word_ext, ODD);
  end else begin : g_wide
    // Words wider than the helper's argument reduce directly.
    assign par = (^word) ^ ODD;
  end

endmodule

// File: rtl/parity_frame_gen.sv
// Streaming parity generator with a per-frame LRC trailer.
// Each accepted WIDTH-bit word is re-emitted one cycle later with its parity
// bit. After every FRAME_LEN words, one trailer beat carries the XOR of the
// frame's words (LRC) and its own parity.
//
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   in_valid/in_ready      : input handshake (in_ready is combinational
//                            from out_ready)
//   in_data                : input word
//   out_valid/out_ready    : output handshake
//   out_data, out_par      : emitted word (or LRC) and its parity
//   out_is_lrc             : beat is the frame trailer
// With PARITY_FRAME_CHECK_EN defined:
//   in_par                 : producer-supplied parity for in_data
//   out_err                : registered with the beat; set when in_par was wrong
//   err_cnt                : saturating count of transferred beats with out_err
module parity_frame_gen
  import parity_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4,
  parameter bit ODD       = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_par,
  output logic             out_is_lrc
`ifdef PARITY_FRAME_CHECK_EN
  ,
  input  logic             in_par,
  output logic             out_err,
  output logic [7:0]       err_cnt
`endif
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [WIDTH-1:0]   lrc_acc_q, lrc_acc_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_par_q, out_par_d;
  logic               out_is_lrc_q, out_is_lrc_d;

  logic               in_data_par;
  logic               lrc_par;
  logic               free;
  logic               in_xfer;

  parity_tree #(.WIDTH(WIDTH), .ODD(ODD)) u_in_par (
    .word (in_data),
    .par  (in_data_par)
  );

  parity_tree #(.WIDTH(WIDTH), .ODD(ODD)) u_lrc_par (
    .word (lrc_acc_q),
    .par  (lrc_par)
  );

  // Output register can take a new beat when empty or being drained.
  assign free     = !out_valid_q || out_ready;
  assign in_ready = free && (state_q == DATA);
  assign in_xfer  = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    lrc_acc_d    = lrc_acc_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_par_d    = out_par_q;
    out_is_lrc_d = out_is_lrc_q;

    if (free) out_valid_d = 1'b0;

    if (state_q == DATA) begin
      if (in_xfer) begin
        out_valid_d  = 1'b1;
        out_data_d   = in_data;
        out_par_d    = in_data_par;
        out_is_lrc_d = 1'b0;
        lrc_acc_d    = lrc_acc_q ^ in_data;
        if (beat_cnt_q == CNT_LAST) begin
          beat_cnt_d = '0;
          state_d    = TRAILER;
        end else begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
    end else if (free) begin
      // Trailer takes the slot; the input sees a one-cycle bubble.
      out_valid_d  = 1'b1;
      out_data_d   = lrc_acc_q;
      out_par_d    = lrc_par;
      out_is_lrc_d = 1'b1;
      lrc_acc_d    = '0;
      state_d      = DATA;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= DATA;
      beat_cnt_q   <= '0;
      lrc_acc_q    <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_par_q    <= 1'b0;
      out_is_lrc_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      lrc_acc_q    <= lrc_acc_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_par_q    <= out_par_d;
      out_is_lrc_q <= out_is_lrc_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_par    = out_par_q;
  assign out_is_lrc = out_is_lrc_q;

`ifdef PARITY_FRAME_CHECK_EN
  logic       out_err_q, out_err_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    out_err_d = out_err_q;
    err_cnt_d = err_cnt_q;
    if (state_q == DATA) begin
      if (in_xfer) out_err_d = (in_par != in_data_par);
    end else if (free) begin
      out_err_d = 1'b0;
    end
    if (out_valid_q && out_ready && out_err_q && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_err_q <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      out_err_q <= out_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign out_err = out_err_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_parity_frame_gen.sv
// Bench for parity_frame_gen. Three instances:
//   0: ODD=0 FRAME_LEN=4   1: ODD=1 FRAME_LEN=4   2: ODD=0 FRAME_LEN=1
// A reference model per instance turns accepted words into the expected beat
// stream (words plus one LRC trailer per frame) held in a small FIFO.
module tb_parity_frame_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] in_valid, in_ready, out_valid, out_ready, out_par, out_is_lrc;
  logic [7:0] in_data  [3];
  logic [7:0] out_data [3];
`ifdef PARITY_FRAME_CHECK_EN
  logic [2:0] in_par, out_err;
  logic [7:0] err_cnt [3];
  bit         inject [3];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    parity_frame_gen #(
      .WIDTH     (8),
      .FRAME_LEN ((g == 2) ? 1 : 4),
      .ODD       (g == 1)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .in_data    (in_data[g]),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .out_data   (out_data[g]),
      .out_par    (out_par[g]),
      .out_is_lrc (out_is_lrc[g])
`ifdef PARITY_FRAME_CHECK_EN
      ,
      .in_par     (in_par[g]),
      .out_err    (out_err[g]),
      .err_cnt    (err_cnt[g])
`endif
    );
  end

  int n_chk = 0;
  int n_fail = 0;

  int         odd_p  [3] = '{0, 1, 0};
  int         flen_p [3] = '{4, 4, 1};
  logic [7:0] acc    [3];
  int         cnt    [3];
  bit         pend   [3];
  bit         hold   [3];
  logic [9:0] held   [3];
  logic [9:0] last_beat [3];
  logic [9:0] eq [3][64];
  int         wr [3];
  int         rd [3];

  // Parity from the bit count: even parity is popcount mod 2.
  function automatic logic mpar(input logic [7:0] d, input int odd);
    return 1'(($countones(d) + odd) % 2);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      acc[k] = 8'h00; cnt[k] = 0; pend[k] = 1'b0; hold[k] = 1'b0;
      wr[k] = 0; rd[k] = 0; last_beat[k] = 10'h000;
    end
  endtask

  // One cycle on instance k, entered and left at a falling edge.
  task automatic step(input int k, input bit v, input logic [7:0] d, input bit r);
    logic [9:0] beat;
    logic       exp_rdy;
    beat = {out_is_lrc[k], out_par[k], out_data[k]};
    if (hold[k]) begin
      n_chk++;
      if (beat !== held[k] || out_valid[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL hold dut%0d: got v=%b beat=%h, want v=1 beat=%h", k, out_valid[k], beat, held[k]);
      end
    end
    if (pend[k] && out_valid[k] && out_is_lrc[k]) pend[k] = 1'b0;
    in_valid[k] = v; in_data[k] = d; out_ready[k] = r;
`ifdef PARITY_FRAME_CHECK_EN
    in_par[k] = mpar(d, odd_p[k]) ^ inject[k];
`endif
    #1;
    exp_rdy = (!out_valid[k] || r) && !pend[k];
    n_chk++;
    if (in_ready[k] !== exp_rdy) begin
      n_fail++;
      $display("FAIL in_ready dut%0d: got %b, want %b", k, in_ready[k], exp_rdy);
    end
    if (out_valid[k] && r) begin
      n_chk++;
      if (rd[k] == wr[k]) begin
        n_fail++;
        $display("FAIL extra_beat dut%0d: got %h, want no beat", k, beat);
      end else begin
        if (beat !== eq[k][rd[k] % 64]) begin
          n_fail++;
          $display("FAIL beat dut%0d #%0d: got %h, want %h", k, rd[k], beat, eq[k][rd[k] % 64]);
        end
        last_beat[k] = beat;
        rd[k]++;
      end
    end
    hold[k] = out_valid[k] && !r;
    held[k] = beat;
    if (v && in_ready[k]) begin
      eq[k][wr[k] % 64] = {1'b0, mpar(d, odd_p[k]), d};
      wr[k]++;
      acc[k] ^= d;
      cnt[k]++;
      if (cnt[k] == flen_p[k]) begin
        eq[k][wr[k] % 64] = {1'b1, mpar(acc[k], odd_p[k]), acc[k]};
        wr[k]++;
        acc[k] = 8'h00; cnt[k] = 0; pend[k] = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input int k);
    for (int i = 0; i < 6; i++) step(k, 1'b0, 8'h00, 1'b1);
    n_chk++;
    if (rd[k] != wr[k]) begin
      n_fail++;
      $display("FAIL drain dut%0d: got %0d beats out, want %0d", k, rd[k], wr[k]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (out_valid[k] !== 1'b0 || out_data[k] !== 8'h00 || out_par[k] !== 1'b0 || out_is_lrc[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset dut%0d: got v=%b d=%h p=%b l=%b, want all 0", k, out_valid[k], out_data[k], out_par[k], out_is_lrc[k]);
      end
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    step(0, 1'b1, 8'h01, 1'b1);
    step(0, 1'b1, 8'h03, 1'b1);
    step(0, 1'b1, 8'h07, 1'b1);
    step(0, 1'b1, 8'h0F, 1'b1);
    drain(0);
    n_chk++;
    if (last_beat[0] !== 10'h20A) begin
      n_fail++;
      $display("FAIL basic_lrc: got %h, want 20a", last_beat[0]);
    end
  endtask

  task automatic test_odd();
    step(1, 1'b1, 8'h00, 1'b1);
    step(1, 1'b1, 8'hFF, 1'b1);
    n_chk++;
    if (last_beat[1] !== 10'h100) begin
      n_fail++;
      $display("FAIL odd_00: got %h, want 100", last_beat[1]);
    end
    step(1, 1'b1, 8'h00, 1'b1);
    n_chk++;
    if (last_beat[1] !== 10'h1FF) begin
      n_fail++;
      $display("FAIL odd_ff: got %h, want 1ff", last_beat[1]);
    end
    step(1, 1'b1, 8'h00, 1'b1);
    drain(1);
    n_chk++;
    if (last_beat[1] !== 10'h3FF) begin
      n_fail++;
      $display("FAIL odd_lrc: got %h, want 3ff", last_beat[1]);
    end
  endtask

  task automatic test_backpressure();
    step(0, 1'b1, 8'h01, 1'b1);
    step(0, 1'b1, 8'h03, 1'b1);
    for (int i = 0; i < 3; i++) step(0, 1'b1, 8'h07, 1'b0);
    step(0, 1'b1, 8'h07, 1'b1);
    step(0, 1'b1, 8'h0F, 1'b1);
    drain(0);
    n_chk++;
    if (last_beat[0] !== 10'h20A) begin
      n_fail++;
      $display("FAIL bp_lrc: got %h, want 20a", last_beat[0]);
    end
  endtask

  task automatic test_reset_mid();
    step(0, 1'b1, 8'h01, 1'b1);
    step(0, 1'b1, 8'h03, 1'b1);
    in_valid[0] = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (out_valid[0] !== 1'b0 || out_data[0] !== 8'h00 || out_par[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: got v=%b d=%h p=%b, want 0 0 0", out_valid[0], out_data[0], out_par[0]);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(0, 1'b1, 8'h10, 1'b1);
    step(0, 1'b1, 8'h20, 1'b1);
    step(0, 1'b1, 8'h40, 1'b1);
    step(0, 1'b1, 8'h80, 1'b1);
    drain(0);
    n_chk++;
    if (last_beat[0] !== 10'h2F0 || rd[0] != 5) begin
      n_fail++;
      $display("FAIL rst_mid_lrc: got %h after %0d beats, want 2f0 after 5", last_beat[0], rd[0]);
    end
  endtask

  task automatic test_frame1();
    int base;
    base = rd[2];
    step(2, 1'b1, 8'h5A, 1'b1);
    step(2, 1'b1, 8'h3C, 1'b1);
    step(2, 1'b1, 8'h3C, 1'b1);
    drain(2);
    n_chk++;
    if (last_beat[2] !== 10'h23C || rd[2] - base != 4) begin
      n_fail++;
      $display("FAIL frame1: got %h after %0d beats, want 23c after 4", last_beat[2], rd[2] - base);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 300; i++)
        step(k, 1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0));
      drain(k);
    end
  endtask

`ifdef PARITY_FRAME_CHECK_EN
  task automatic test_check();
    int e0;
    e0 = err_cnt[0];
    inject[0] = 1'b1;
    step(0, 1'b1, 8'h01, 1'b1);
    inject[0] = 1'b0;
    n_chk++;
    if (out_err[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set: got %b, want 1", out_err[0]);
    end
    step(0, 1'b1, 8'h03, 1'b1);
    n_chk++;
    if (out_err[0] !== 1'b0 || int'(err_cnt[0]) != e0 + 1) begin
      n_fail++;
      $display("FAIL err_clr: got err=%b cnt=%0d, want 0 %0d", out_err[0], err_cnt[0], e0 + 1);
    end
    step(0, 1'b1, 8'h07, 1'b1);
    step(0, 1'b1, 8'h0F, 1'b1);
    step(0, 1'b0, 8'h00, 1'b1);
    n_chk++;
    if (out_is_lrc[0] !== 1'b1 || out_err[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL err_trailer: got lrc=%b err=%b, want 1 0", out_is_lrc[0], out_err[0]);
    end
    drain(0);
  endtask
`endif

  initial begin
    rst = 1'b1;
    in_valid = '0;
    out_ready = '0;
    for (int k = 0; k < 3; k++) in_data[k] = 8'h00;
`ifdef PARITY_FRAME_CHECK_EN
    in_par = '0;
    for (int k = 0; k < 3; k++) inject[k] = 1'b0;
`endif
    test_reset();
    test_basic();
    test_odd();
    test_backpressure();
    test_reset_mid();
    test_frame1();
`ifdef PARITY_FRAME_CHECK_EN
    test_check();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/parity_frame_gen.md
Name: parity_frame_gen

Overview:
- Streaming parity generator, the parametrised successor to the fixed 3-input parity generator.
- Accepts WIDTH-bit words over a valid/ready handshake and emits each word with its per-word parity bit.
- After every FRAME_LEN data words, inserts one trailer beat carrying the longitudinal redundancy check (LRC, the bitwise XOR of the frame's words) plus that trailer's own parity bit.
- Sits between a word producer and a serialiser/link in the lab datapath.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- FRAME_LEN, 4, data words per frame before the LRC trailer (>=1).
- ODD, 0, 0 = even parity (par = XOR of bits); 1 = odd parity (par = inverted XOR).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer has a word.
- in_ready  out  1  block accepts a word this cycle.
- in_data  in  WIDTH  data word.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  WIDTH  data word or LRC.
- out_par  out  1  parity of out_data per ODD.
- out_is_lrc  out  1  beat is the frame trailer.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_par=0, out_is_lrc=0.
  - lrc_acc=0, beat_cnt=0, state=DATA.
- Output stage is a single register. Slot free when `free = !out_valid || out_ready`.
- in_ready = free && (state==DATA). It is combinational from out_ready.
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Latency: an accepted word appears on out_* the next cycle. Throughput is 1 word/cycle when out_ready is held high.
- State DATA, on input transfer:
  - out_data <= in_data; out_par <= (^in_data)^ODD; out_is_lrc <= 0; out_valid <= 1.
  - lrc_acc <= lrc_acc ^ in_data.
  - If beat_cnt==FRAME_LEN-1: beat_cnt <= 0, go TRAILER. Otherwise beat_cnt++.
- State TRAILER, when free:
  - out_data <= lrc_acc; out_par <= (^lrc_acc)^ODD; out_is_lrc <= 1; out_valid <= 1.
  - lrc_acc <= 0; go DATA.
  - The trailer costs one input bubble cycle.
- When free and no load occurs, out_valid <= 0.
- Backpressure: while out_valid && !out_ready, all out_* hold stable and in_ready=0.
- FRAME_LEN=1: pattern is word, LRC (equal to that word), word, LRC, ...
- beat_cnt width = $clog2(FRAME_LEN) with a minimum of 1 bit. It wraps to 0 only at end of frame.
- Reset mid-frame: the partial frame is discarded with no trailer emitted, and the next frame starts clean.

Optional Feature:
- Macro: PARITY_FRAME_CHECK_EN.
- Defined:
  - Extra ports: in_par (in, 1) and out_err (out, 1), plus err_cnt (out, 8).
  - On a DATA input transfer, out_err <= (in_par != (^in_data)^ODD). out_err is registered with the beat and is 0 on trailer beats.
  - err_cnt increments (saturating at 255) on each output transfer with out_err=1. It resets to 0.
- Undefined: these ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package parity_pkg:
  - state enum {DATA, TRAILER}.
  - Function par_of(word, odd) returning the reduced XOR with the odd inversion.
- One sub-module, parity_tree: parametrised WIDTH/ODD combinational reduction. It is instanced twice, on in_data and on lrc_acc.

Test Plan:
- Basic frame (WIDTH=8, FRAME_LEN=4, ODD=0, out_ready=1): inputs 0x01, 0x03, 0x07, 0x0F -> beats (01,p1), (03,p0), (07,p1), (0F,p0), then (0A,p0,lrc=1). in_ready=0 for exactly the trailer cycle.
- Odd parity (ODD=1): input 0xFF -> out_par=1. Input 0x00 -> out_par=1. Trailer of frame 0x00, 0xFF, 0x00, 0x00 -> LRC=0xFF, par=1.
- Backpressure: hold out_ready=0 for 3 cycles mid-frame -> out_data/out_par/out_valid stable, in_ready=0, no word lost or duplicated. LRC still 0x0A for the basic stimulus.
- Reset mid-frame: after 2 of 4 words assert rst -> outputs 0 immediately. Next 4 words 0x10, 0x20, 0x40, 0x80 -> LRC=0xF0, par=0, with no stale trailer.
- FRAME_LEN=1 with back-to-back 0x5A, 0x3C -> beats 5A(p0), LRC 5A(p0), 3C(p0), LRC 3C(p0).
- With PARITY_FRAME_CHECK_EN: send 0x01 with in_par=0 -> out_err=1, err_cnt=1. Send 0x03 with in_par=0 -> out_err=0. Trailer beat -> out_err=0.
